// File: rtl/micro_pkg.sv
// Shared definitions for the frame-sequenced micro core: FSM states, instruction
// opcodes/functs and register-role boundaries.
package micro_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_FRAME,
    S_FETCH,
    S_EXEC
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  localparam int NREG    = 16;
  localparam int IN_BASE = 1;

  // Output registers occupy the top nch slots of the register file.
  function automatic int out_base(input int nch);
    return NREG - nch;
  endfunction

endpackage

// File: rtl/prog_ram.sv
// Program store: one write port, one registered read port. Not reset, so a
// loaded program survives rst.
module prog_ram #(
  parameter int PDEPTH = 16,
  parameter int AW     = $clog2(PDEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [PDEPTH];

  // A same-cycle write to raddr returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/micro_frame_core.sv
// Frame-periodic micro sequencer: runs a small program once per frame on a
// snapshot of the input channels and publishes output registers on HALT.
//
// state        | meaning
// S_IDLE       | run low, nothing executes
// S_WAIT_FRAME | program done, waiting for next frame_start
// S_FETCH      | program word read from prog_ram at pc
// S_EXEC       | decode, execute, write back, advance pc or finish frame
module micro_frame_core
  import micro_pkg::*;
#(
  parameter int DW     = 18,
  parameter int NCH    = 2,
  parameter int PDEPTH = 16,
  parameter int PERIOD = 250000,
  localparam int AW    = $clog2(PDEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [31:0]       prog_data,
  input  logic [NCH*DW-1:0] in_ch,
  output logic [NCH*DW-1:0] out_ch,
  output logic              busy,
  output logic              overrun,
  output logic [AW-1:0]     pc
);

  localparam int TW       = $clog2(PERIOD + 1);
  localparam int OUT_BASE = out_base(NCH);

  state_t            state, state_nxt;
  logic [TW-1:0]     tmr;
  logic              frame_start;
  logic [31:0]       instr;
  logic [DW-1:0]     regs [NREG];

  logic [5:0]        opcode, funct;
  logic [3:0]        rs, rt, rd;
  logic [15:0]       imm;
  logic              unused_bits;
  logic [DW-1:0]     op_a, op_b, imm_x;

  logic              wr_en, wr_ok, is_halt, pc_last;
  logic [3:0]        wr_idx;
  logic [DW-1:0]     wr_val;
  logic [NCH*DW-1:0] out_next;

  logic              do_snap, pc_clr, pc_inc, do_wb, do_pub, set_ovr;

  prog_ram #(.PDEPTH(PDEPTH), .AW(AW)) u_prog_ram (
    .clk   (clk),
    .we    (prog_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc),
    .rdata (instr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           tmr <= '0;
    else if (!run)                      tmr <= '0;
    else if (tmr == TW'(PERIOD - 1))    tmr <= '0;
    else                                tmr <= tmr + 1'b1;
  end

  assign frame_start = run && (tmr == '0);

  assign opcode      = instr[31:26];
  assign rs          = instr[24:21];
  assign rt          = instr[19:16];
  assign rd          = instr[14:11];
  assign funct       = instr[5:0];
  assign imm         = instr[15:0];
  assign unused_bits = ^{instr[25], instr[20], instr[10:6]};

  assign op_a  = regs[rs];
  assign op_b  = regs[rt];
  assign imm_x = DW'($signed(imm));

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = rd;
    wr_val  = '0;
    is_halt = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        wr_idx = rd;
        unique case (funct)
          FN_ADD:  begin wr_en = 1'b1; wr_val = op_a + op_b; end
          FN_SUB:  begin wr_en = 1'b1; wr_val = op_a - op_b; end
          FN_AND:  begin wr_en = 1'b1; wr_val = op_a & op_b; end
          FN_OR:   begin wr_en = 1'b1; wr_val = op_a | op_b; end
          default: ;
        endcase
      end
      OP_ADDI: begin
        wr_en  = 1'b1;
        wr_idx = rt;
        wr_val = op_a + imm_x;
      end
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

  // r0 and the input snapshot registers are never written by instructions.
  assign wr_ok   = wr_en && (int'(wr_idx) > NCH);
  assign pc_last = (pc == AW'(PDEPTH - 1));

  // Published values include a write made by the finishing instruction itself.
  always_comb begin
    out_next = out_ch;
    for (int k = 0; k < NCH; k++) begin
      if (wr_ok && (int'(wr_idx) == OUT_BASE + k)) out_next[k*DW +: DW] = wr_val;
      else                                         out_next[k*DW +: DW] = regs[OUT_BASE + k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_snap   = 1'b0;
    pc_clr    = 1'b0;
    pc_inc    = 1'b0;
    do_wb     = 1'b0;
    do_pub    = 1'b0;
    set_ovr   = 1'b0;
    unique case (state)
      S_IDLE: if (run) state_nxt = S_WAIT_FRAME;
      S_WAIT_FRAME: begin
        if (!run) state_nxt = S_IDLE;
        else if (frame_start) begin
          state_nxt = S_FETCH;
          do_snap   = 1'b1;
          pc_clr    = 1'b1;
        end
      end
      S_FETCH, S_EXEC: begin
        if (!run) state_nxt = S_IDLE;
        else if (frame_start) begin
          state_nxt = S_FETCH;
          do_snap   = 1'b1;
          pc_clr    = 1'b1;
          set_ovr   = 1'b1;
        end else if (state == S_FETCH) begin
          state_nxt = S_EXEC;
        end else begin
          do_wb = wr_ok;
          if (is_halt || pc_last) begin
            do_pub    = 1'b1;
            state_nxt = S_WAIT_FRAME;
          end else begin
            pc_inc    = 1'b1;
            state_nxt = S_FETCH;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_FETCH) || (state == S_EXEC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= '0;
      overrun <= 1'b0;
      out_ch  <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (pc_clr)      pc <= '0;
      else if (pc_inc) pc <= pc + 1'b1;
      if (set_ovr) overrun <= 1'b1;
      if (do_snap) begin
        for (int k = 0; k < NCH; k++) regs[IN_BASE + k] <= in_ch[k*DW +: DW];
      end
      if (do_wb)  regs[wr_idx] <= wr_val;
      if (do_pub) out_ch <= out_next;
    end
  end

endmodule

// File: tb/tb_micro_frame_core.sv
// Directed bench for micro_frame_core: a vector table of short programs plus
// hand-written timing, implicit-halt, overrun, run-drop and async-reset sequences.
module tb_micro_frame_core;
  localparam int DW = 18;
  localparam int NCH = 2;
  localparam int PDEPTH = 16;
  localparam int AW = 4;
  localparam logic [31:0] HALT = 32'hFC00_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run = 1'b0;
  logic prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic [NCH*DW-1:0] in_ch = '0;
  logic [NCH*DW-1:0] out_a, out_b;
  logic busy_a, busy_b, overrun_a, overrun_b;
  logic [AW-1:0] pc_a, pc_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  micro_frame_core #(.DW(DW), .NCH(NCH), .PDEPTH(PDEPTH), .PERIOD(40)) dut_a (
    .clk(clk), .rst(rst), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .in_ch(in_ch), .out_ch(out_a), .busy(busy_a),
    .overrun(overrun_a), .pc(pc_a));

  micro_frame_core #(.DW(DW), .NCH(NCH), .PDEPTH(PDEPTH), .PERIOD(20)) dut_b (
    .clk(clk), .rst(rst), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .in_ch(in_ch), .out_ch(out_b), .busy(busy_b),
    .overrun(overrun_b), .pc(pc_b));

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'b0, 1'b0, 4'(rs), 1'b0, 4'(rt), 1'b0, 4'(rd), 5'b0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 1'b0, 4'(rs), 1'b0, 4'(rt), imm};
  endfunction

  function automatic logic [DW-1:0] ch(input logic [NCH*DW-1:0] v, input int k);
    return v[k*DW +: DW];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    prog_we = 1'b1;
    prog_addr = AW'(a);
    prog_data = d;
    tick(1);
    prog_we = 1'b0;
  endtask

  task automatic do_reset();
    run = 1'b0;
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  task automatic wait_busy(input logic lvl, input string nm);
    for (int i = 0; i < 200; i++) begin
      if (busy_a === lvl) break;
      tick(1);
    end
    chk(nm, busy_a, lvl);
  endtask

  typedef struct {
    string         name;
    logic [31:0]   prog [6];
    logic [DW-1:0] in0, in1, exp0, exp1;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{"add", '{enc_r(1, 2, 14, 6'h20), enc_r(1, 0, 15, 6'h20), HALT, HALT, HALT, HALT},
               18'd100, 18'd23, 18'd123, 18'd100};
    tbl[1] = '{"sub_wrap", '{enc_r(0, 1, 14, 6'h22), HALT, HALT, HALT, HALT, HALT},
               18'd1, 18'd0, 18'h3FFFF, 18'd0};
    tbl[2] = '{"and_or", '{enc_r(1, 2, 14, 6'h24), enc_r(1, 2, 15, 6'h25), HALT, HALT, HALT, HALT},
               18'h0F0F0, 18'h3C3C3, 18'h0C0C0, 18'h3F3F3};
    tbl[3] = '{"addi_sext", '{enc_i(6'h08, 0, 15, 16'hFFFF), enc_i(6'h08, 0, 14, 16'h7FFF), HALT, HALT, HALT, HALT},
               18'd0, 18'd0, 18'h07FFF, 18'h3FFFF};
    tbl[4] = '{"ro_regs", '{enc_i(6'h08, 0, 1, 16'd55), enc_i(6'h08, 0, 0, 16'd9), enc_r(1, 0, 14, 6'h20),
                            enc_i(6'h08, 0, 15, 16'd3), HALT, HALT},
               18'd77, 18'd0, 18'd77, 18'd3};
    tbl[5] = '{"nop_gpr", '{enc_i(6'h05, 1, 15, 16'd1), enc_r(1, 2, 14, 6'h21), enc_i(6'h08, 1, 5, 16'd10),
                            enc_r(5, 2, 15, 6'h20), HALT, HALT},
               18'd1000, 18'd2, 18'd0, 18'd1012};
    tbl[6] = '{"add_wrap", '{enc_r(1, 2, 14, 6'h20), enc_i(6'h08, 1, 15, 16'hFFFD), HALT, HALT, HALT, HALT},
               18'h3FFFF, 18'd2, 18'd1, 18'h3FFFC};

    // Reset state
    tick(2);
    chk("rst_out", out_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_pc", pc_a, 0);
    chk("rst_overrun", overrun_a, 0);
    rst = 1'b1;
    tick(1);

    // ADDI r15,r1,5; HALT with exact issue timing
    wr(0, enc_i(6'h08, 1, 15, 16'd5));
    wr(1, HALT);
    in_ch = {18'd7, 18'd100};
    run = 1'b1;
    wait_busy(1'b1, "t1_start");
    chk("t1_fetch0_pc", pc_a, 0);
    tick(2);
    chk("t1_fetch1_pc", pc_a, 1);
    tick(1);
    chk("t1_exec1_busy", busy_a, 1);
    chk("t1_exec1_pc", pc_a, 1);
    tick(1);
    chk("t1_done_busy", busy_a, 0);
    chk("t1_out_ch1", ch(out_a, 1), 105);
    chk("t1_out_ch0", ch(out_a, 0), 0);

    // Table of short programs
    for (int v = 0; v < 7; v++) begin
      do_reset();
      in_ch = {tbl[v].in1, tbl[v].in0};
      for (int w = 0; w < 6; w++) wr(w, tbl[v].prog[w]);
      run = 1'b1;
      wait_busy(1'b1, {tbl[v].name, "_start"});
      wait_busy(1'b0, {tbl[v].name, "_end"});
      chk({tbl[v].name, "_ch0"}, ch(out_a, 0), tbl[v].exp0);
      chk({tbl[v].name, "_ch1"}, ch(out_a, 1), tbl[v].exp1);
    end

    // No HALT: implicit halt after the 16th EXEC
    do_reset();
    for (int w = 0; w < 16; w++) wr(w, enc_i(6'h08, 15, 15, 16'd1));
    run = 1'b1;
    wait_busy(1'b1, "nohalt_start");
    begin
      int n;
      n = 0;
      for (int i = 0; i < 40; i++) begin
        if (!busy_a) break;
        n++;
        if (n == 32) chk("nohalt_out_before", ch(out_a, 1), 0);
        tick(1);
      end
      chk("nohalt_busy_cycles", n, 32);
    end
    chk("nohalt_out_after", ch(out_a, 1), 16);
    chk("nohalt_pc_nowrap", pc_a, 15);

    // Overrun on the short-period instance: 12 instructions then HALT
    do_reset();
    for (int w = 0; w < 12; w++) wr(w, enc_i(6'h08, 15, 15, 16'd1));
    wr(12, HALT);
    run = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (overrun_b) break;
      tick(1);
    end
    chk("ovr_flag", overrun_b, 1);
    chk("ovr_pc_restart", pc_b, 0);
    chk("ovr_busy", busy_b, 1);
    chk("ovr_out_unchanged", out_b, 0);
    tick(30);
    chk("ovr_sticky", overrun_b, 1);
    chk("ovr_out_still", out_b, 0);
    chk("long_period_out", ch(out_a, 1), 12);
    chk("long_period_no_ovr", overrun_a, 0);

    // run dropped mid-frame
    do_reset();
    run = 1'b1;
    wait_busy(1'b1, "drop_f1_start");
    wait_busy(1'b0, "drop_f1_end");
    chk("drop_f1_out", ch(out_a, 1), 12);
    wait_busy(1'b1, "drop_f2_start");
    tick(5);
    run = 1'b0;
    tick(1);
    chk("drop_busy", busy_a, 0);
    chk("drop_out_held", ch(out_a, 1), 12);
    tick(3);
    chk("drop_out_held_later", ch(out_a, 1), 12);

    // Asynchronous reset mid-EXEC
    run = 1'b1;
    wait_busy(1'b1, "arst_start");
    tick(1);
    chk("arst_in_exec", busy_a, 1);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_out", out_a, 0);
    chk("arst_busy", busy_a, 0);
    chk("arst_pc", pc_a, 0);
    chk("arst_overrun_b", overrun_b, 0);
    run = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/micro_frame_core.md
MICRO_FRAME_CORE -- requirements
Module: micro_frame_core

Interface
REQ-001 The block SHALL have parameter DW, default 18, meaning data/register width.
REQ-002 The block SHALL have parameter NCH, default 2 (legal 1..4), meaning the number of input and output channels.
REQ-003 The block SHALL have parameter PDEPTH, default 16 (power of 2, 4..64), meaning the program memory depth in words.
REQ-004 The block SHALL have parameter PERIOD, default 250000, meaning frame length in clk cycles (5 ms at 50 MHz).
REQ-005 The block SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 The block SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-007 The block SHALL have port run  in  1  1 = frames execute; 0 = hold in IDLE.
REQ-008 The block SHALL have port prog_we  in  1  program word write strobe.
REQ-009 The block SHALL have port prog_addr  in  clog2(PDEPTH)  program write address.
REQ-010 The block SHALL have port prog_data  in  32  program word.
REQ-011 The block SHALL have port in_ch  in  NCH*DW  input channels (REF/POT class), channel k at [k*DW +: DW].
REQ-012 The block SHALL have port out_ch  out  NCH*DW  output channels (PWM class).
REQ-013 The block SHALL have port busy  out  1  high while a frame program executes.
REQ-014 The block SHALL have port overrun  out  1  sticky, frame ended before HALT.
REQ-015 The block SHALL have port pc  out  clog2(PDEPTH)  current program counter.

Function
REQ-016 Encoding SHALL be: opcode[31:26], rs[24:21], rt[19:16], rd[14:11], funct[5:0], imm[15:0], sign-extended to DW.
REQ-017 opcode 000000 SHALL be R-type: funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, with rd = rs op rt.
REQ-018 opcode 001000 ADDI SHALL compute rt = rs + ext(imm); opcode 111111 SHALL be HALT; any other opcode/funct SHALL be a NOP.
REQ-019 Arithmetic SHALL be DW-bit two's-complement, wrapping, with no flags.
REQ-020 Register 0 SHALL read 0, and writes to it SHALL be ignored.
REQ-021 Registers 1..NCH SHALL read in_ch snapshots latched at frame start and SHALL be read-only.
REQ-022 Registers 16-NCH..15 SHALL be output registers; the rest SHALL be general purpose.
REQ-023 The frame timer SHALL count 0..PERIOD-1 while run=1, SHALL wrap, and SHALL be held at 0 when run=0; frame_start SHALL be asserted at count 0.
REQ-024 The FSM states SHALL be IDLE, WAIT_FRAME, FETCH, EXEC.
- IDLE→WAIT_FRAME on run=1.
- WAIT_FRAME→FETCH on frame_start: snapshot inputs, pc=0.
- FETCH: synchronous memory read, 1 cycle.
- EXEC: decode, execute, write back, pc+1 → FETCH; 2 cycles per instruction.
REQ-025 HALT in EXEC SHALL copy all output registers to out_ch in the same cycle and then enter WAIT_FRAME.
REQ-026 Executing the word at pc=PDEPTH-1 without HALT SHALL act as an implicit HALT, with no pc wrap.
REQ-027 On frame_start while in FETCH/EXEC, the block SHALL set overrun, leave out_ch unchanged, and restart the frame (re-snapshot inputs, pc=0, FETCH).
REQ-028 run deasserted mid-frame SHALL abort to IDLE at the next edge with out_ch held; general registers SHALL keep their values.
REQ-029 busy SHALL be 1 exactly in FETCH/EXEC.
REQ-030 prog_we SHALL be accepted in any state; a write to the address currently being fetched SHALL return the old word (read-before-write).
REQ-031 overrun SHALL clear only on reset.

Reset
REQ-032 On reset, the block SHALL enter IDLE with pc=0, timer=0, all registers 0, out_ch=0, busy=0, overrun=0.
REQ-033 Program memory contents SHALL NOT be cleared by reset.

Structure
REQ-034 Opcode/funct constants, register-role boundaries and the state enum SHALL live in shared package micro_pkg.
REQ-035 Program memory SHALL be sub-module prog_ram: single clock, one write port, one synchronous read port, PDEPTH x 32.

Verification
REQ-036 The bench SHALL cover: load ADDI r15,r1,5; HALT; in_ch0=100 → out_ch ch1 (r15)=105 after first frame, then busy low; instruction 2 issues 4 cycles after frame_start.
REQ-037 The bench SHALL cover: SUB r14,r0,r1 with in_ch0=1 → out = 0x3FFFF (DW=18 wrap).
REQ-038 The bench SHALL cover: PERIOD=20 with a 12-instruction program lacking HALT before the limit → overrun=1, out_ch unchanged, pc back to 0.
REQ-039 The bench SHALL cover: program with no HALT and PDEPTH=16 → outputs update after the 16th EXEC.
REQ-040 The bench SHALL cover: run dropped mid-frame → IDLE next cycle, busy=0, out_ch held; rst low asynchronously mid-EXEC → all outputs 0 immediately.
REQ-041 The bench SHALL cover: write to r1 and r0, then read → in_ch snapshot and 0 respectively.
